// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command front-end: default widths, FSM states
// and the opcode encodings understood by the downstream ALU.
package alu_cmd_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned SEL_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_ISSUE,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SHL   = 4'b0010;
    localparam logic [3:0] OP_SHR   = 4'b0011;
    localparam logic [3:0] OP_CMP   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_XNOR  = 4'b1010;
    localparam logic [3:0] OP_NOT   = 4'b1011;
    localparam logic [3:0] OP_NEG   = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1101;
    localparam logic [3:0] OP_SWAP  = 4'b1110;
    localparam logic [3:0] OP_LOAD  = 4'b1111;

endpackage

// File: rtl/alu_cmd_front_btn_sync.sv
// Multi-flop synchronizer with asynchronous active-low clear; the output is the
// last stage of the chain.
module btn_sync
    import alu_cmd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/alu_cmd_front.sv
// Debounced switch/button front-end for the ALU: one enable toggle per press.
// Optional auto-repeat while held is built when ALU_CMD_AUTO_REPEAT_EN is defined.
module alu_cmd_front
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned SEL_W           = SEL_W_DEF,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
`ifdef ALU_CMD_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES   = 25000000
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sw_data,
    input  logic        [SEL_W-1:0]  sw_sel,
    input  logic                     btn_exec,
    output logic signed [DATA_W-1:0] data_out,
    output logic        [SEL_W-1:0]  sel_out,
    output logic                     enable,
    output logic                     busy,
    output logic        [7:0]        cmd_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic rst_n;
    logic btn;

    // Reset asserts asynchronously but leaves reset on a clk edge.
    btn_sync #(.SYNC_STAGES(2)) u_rst_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (1'b1),
        .q     (rst_n)
    );

    btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_exec),
        .q     (btn)
    );

    state_e                     state_q, state_d;
    logic        [CNT_W-1:0]    cnt_q, cnt_d;
    logic signed [DATA_W-1:0]   data_q, data_d;
    logic        [SEL_W-1:0]    sel_q, sel_d;
    logic                       enable_q, enable_d;
    logic        [7:0]          cmd_count_q, cmd_count_d;

`ifdef ALU_CMD_AUTO_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        cmd_count_d = cmd_count_q;
`ifdef ALU_CMD_AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (btn) begin
                    cnt_d   = '0;
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = sw_data;
                    sel_d   = sw_sel;
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                enable_d    = ~enable_q;
                cmd_count_d = cmd_count_q + 8'd1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (!btn) begin
                    cnt_d     = '0;
                    state_d   = ST_RELEASE;
`ifdef ALU_CMD_AUTO_REPEAT_EN
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    data_d    = sw_data;
                    sel_d     = sw_sel;
                    rep_cnt_d = '0;
                    state_d   = ST_ISSUE;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
                end
            end
            ST_RELEASE: begin
                if (btn) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            enable_q    <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            cmd_count_q <= cmd_count_d;
        end
    end

`ifdef ALU_CMD_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign enable    = enable_q;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_alu_cmd_front.sv
// Directed bench for alu_cmd_front with a run-length model of press/release
// acceptance checked against the outputs every cycle.
module tb_alu_cmd_front;

    localparam int DEB  = 4;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_data;
    logic [3:0] sw_sel;
    logic       btn_exec;
    logic [7:0] data_out;
    logic [3:0] sel_out;
    logic       enable;
    logic       busy;
    logic [7:0] cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_front #(
        .DATA_W          (8),
        .SEL_W           (4),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_data   (sw_data),
        .sw_sel    (sw_sel),
        .btn_exec  (btn_exec),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .enable    (enable),
        .busy      (busy),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a press is accepted after DEB+1 consecutive synchronized 1s seen
    // while idle; a release completes after DEB+1 consecutive 0s while held.
    logic [SYNC-1:0] m_pipe;
    int              m_mode;   // 0 idle/pressing, 1 command pending, 2 held
    int              m_run;
    logic            m_en;
    logic [7:0]      m_cnt;
    logic [7:0]      m_data;
    logic [3:0]      m_sel;
    logic            m_btn;
    logic            m_busy;

    assign m_btn  = m_pipe[SYNC-1];
    assign m_busy = (m_mode != 0) || (m_run != 0);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pipe <= '0;
            m_mode <= 0;
            m_run  <= 0;
            m_en   <= 1'b0;
            m_cnt  <= 8'd0;
            m_data <= 8'd0;
            m_sel  <= 4'd0;
        end else begin
            m_pipe <= {m_pipe[SYNC-2:0], btn_exec};
            case (m_mode)
                0: begin
                    if (m_btn) begin
                        if (m_run == DEB) begin
                            m_data <= sw_data;
                            m_sel  <= sw_sel;
                            m_mode <= 1;
                            m_run  <= 0;
                        end else begin
                            m_run <= m_run + 1;
                        end
                    end else begin
                        m_run <= 0;
                    end
                end
                1: begin
                    m_en   <= ~m_en;
                    m_cnt  <= m_cnt + 8'd1;
                    m_mode <= 2;
                    m_run  <= 0;
                end
                default: begin
                    if (!m_btn) begin
                        if (m_run == DEB) begin
                            m_mode <= 0;
                            m_run  <= 0;
                        end else begin
                            m_run <= m_run + 1;
                        end
                    end else begin
                        m_run <= 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_enable", {31'd0, enable}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_cmd_count", {24'd0, cmd_count}, 32'd0);
            check("rst_data_out", {24'd0, data_out}, 32'd0);
            check("rst_sel_out", {28'd0, sel_out}, 32'd0);
        end else begin
            check("enable", {31'd0, enable}, {31'd0, m_en});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("cmd_count", {24'd0, cmd_count}, {24'd0, m_cnt});
            check("data_out", {24'd0, data_out}, {24'd0, m_data});
            check("sel_out", {28'd0, sel_out}, {28'd0, m_sel});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        btn_exec = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(6);
    endtask

    task automatic press(input int hi, input int lo);
        btn_exec = 1'b1;
        cycles(hi);
        btn_exec = 1'b0;
        cycles(lo);
    endtask

    initial begin
        reset    = 1'b0;
        btn_exec = 1'b0;
        sw_data  = 8'h00;
        sw_sel   = 4'h0;
        do_reset();

        // Reset in the middle of a press: no command, everything cleared.
        sw_data  = 8'h3C;
        sw_sel   = 4'h2;
        btn_exec = 1'b1;
        cycles(5);
        #1 reset = 1'b0;
        #1;
        check("midpress_rst_enable", {31'd0, enable}, 32'd0);
        check("midpress_rst_busy", {31'd0, busy}, 32'd0);
        check("midpress_rst_count", {24'd0, cmd_count}, 32'd0);
        check("midpress_rst_data", {24'd0, data_out}, 32'd0);
        do_reset();
        check("after_rst_busy", {31'd0, busy}, 32'd0);

        // Clean press; switches change while held and must not be captured.
        sw_data  = 8'h85;
        sw_sel   = 4'hF;
        btn_exec = 1'b1;
        cycles(10);
        sw_data = 8'h10;
        cycles(2);
        check("press_data", {24'd0, data_out}, 32'h85);
        check("press_sel", {28'd0, sel_out}, 32'hF);
        check("press_enable", {31'd0, enable}, 32'd1);
        check("press_count", {24'd0, cmd_count}, 32'd1);
        check("press_busy", {31'd0, busy}, 32'd1);

        // Release bounce: short low/high runs must not end the hold.
        for (int i = 0; i < 3; i++) begin
            btn_exec = 1'b0;
            cycles(2);
            btn_exec = 1'b1;
            cycles(2);
        end
        btn_exec = 1'b0;
        check("bounce_busy", {31'd0, busy}, 32'd1);
        check("freeze_data", {24'd0, data_out}, 32'h85);
        cycles(20);
        check("released_busy", {31'd0, busy}, 32'd0);
        check("released_enable", {31'd0, enable}, 32'd1);
        check("released_count", {24'd0, cmd_count}, 32'd1);
        check("released_data", {24'd0, data_out}, 32'h85);

        // Second command toggles enable back to 0.
        sw_sel = 4'hE;
        press(12, 20);
        check("second_enable", {31'd0, enable}, 32'd0);
        check("second_count", {24'd0, cmd_count}, 32'd2);
        check("second_sel", {28'd0, sel_out}, 32'hE);
        check("second_data", {24'd0, data_out}, 32'h10);

        // Glitch of two synchronized cycles is rejected.
        sw_data = 8'h77;
        press(2, 20);
        check("glitch_enable", {31'd0, enable}, 32'd0);
        check("glitch_count", {24'd0, cmd_count}, 32'd2);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_data", {24'd0, data_out}, 32'h10);

        // 256 presses from reset wrap the counter and leave enable low.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            sw_data = 8'(i);
            sw_sel  = 4'(i);
            press(8, 10);
        end
        cycles(10);
        check("wrap_count", {24'd0, cmd_count}, 32'd0);
        check("wrap_enable", {31'd0, enable}, 32'd0);
        check("wrap_busy", {31'd0, busy}, 32'd0);
        check("wrap_data", {24'd0, data_out}, 32'hFF);
        check("wrap_sel", {28'd0, sel_out}, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
